// File: rtl/cpu_param.sv
// Width-parametrised multi-cycle CPU: 16-bit instruction word, 8 x DATA_W register
// file, barrel-free single-bit shifter on the B operand and N/V/Z status flags.
module cpu_param #(
    parameter int unsigned DATA_W     = 16,
    parameter bit          IMM_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w
);

    localparam int unsigned MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic              n_q, n_d;
    logic              v_q, v_d;
    logic              z_q, z_d;
    logic              w_q, w_d;
    logic [DATA_W-1:0] regs_q [0:7];
    logic [DATA_W-1:0] regs_d [0:7];

    // Instruction field decode from the held IR
    logic [2:0]        opc, rn, rd, rm;
    logic [1:0]        op, sh;
    logic [7:0]        imm8;
    logic              is_mov_imm, is_mov_sh, is_alu, is_cmp;
    logic [DATA_W-1:0] imm_ext;

    assign opc        = ir_q[15:13];
    assign op         = ir_q[12:11];
    assign rn         = ir_q[10:8];
    assign rd         = ir_q[7:5];
    assign sh         = ir_q[4:3];
    assign rm         = ir_q[2:0];
    assign imm8       = ir_q[7:0];
    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_sh  = (opc == 3'b110) && (op == 2'b00);
    assign is_alu     = (opc == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign imm_ext    = IMM_SIGNED ? {{(DATA_W-8){imm8[7]}}, imm8}
                                   : {{(DATA_W-8){1'b0}}, imm8};

    // Shifter and ALU on the latched operands
    logic [DATA_W-1:0] b_sh, sum, diff, alu_res;
    logic              sub_ovf;

    always_comb begin
        b_sh = b_q;
        case (sh)
            2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[MSB:1]};
            2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
        sum     = a_q + b_sh;
        diff    = a_q - b_sh;
        sub_ovf = (a_q[MSB] ^ b_sh[MSB]) & (diff[MSB] ^ a_q[MSB]);
        case (op)
            2'b00:   alu_res = sum;
            2'b01:   alu_res = diff;
            2'b10:   alu_res = a_q & b_sh;
            default: alu_res = ~b_sh;
        endcase
    end

    // Next-state, register-file and flag update logic
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        n_d     = n_q;
        v_d     = v_q;
        z_d     = z_q;
        regs_d  = regs_q;
        case (state_q)
            S_WAIT: begin
                if (load) ir_d = in;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)               state_d = S_WR_IMM;
                else if (is_mov_sh || is_alu) state_d = S_GET_A;
                else                          state_d = S_WAIT;
            end
            S_WR_IMM: begin
                regs_d[rn] = imm_ext;
                state_d    = S_WAIT;
            end
            S_GET_A: begin
                a_d     = is_mov_sh ? '0 : regs_q[rn];
                state_d = S_GET_B;
            end
            S_GET_B: begin
                b_d     = regs_q[rm];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_cmp) begin
                    n_d     = diff[MSB];
                    z_d     = (diff == '0);
                    v_d     = sub_ovf;
                    state_d = S_WAIT;
                end else begin
                    c_d     = alu_res;
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: begin
                regs_d[rd] = c_q;
                state_d    = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
        w_d = (state_d == S_WAIT);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            w_q     <= 1'b1;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            w_q     <= w_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
    assign w   = w_q;

endmodule

// File: tb/tb_cpu_param.sv
// Bench for cpu_param: 16-bit and 24-bit instances run the same program against an
// arithmetic reference model of the instruction set.
module tb_cpu_param;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic [15:0] out16;
    logic [23:0] out24;
    logic        n16, v16, z16, w16;
    logic        n24, v24, z24, w24;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_param #(.DATA_W(16), .IMM_SIGNED(1'b1)) u_dut16 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .out(out16), .N(n16), .V(v16), .Z(z16), .w(w16)
    );

    cpu_param #(.DATA_W(24), .IMM_SIGNED(1'b1)) u_dut24 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .out(out24), .N(n24), .V(v24), .Z(z24), .w(w24)
    );

    // Reference model state: index 0 = 16-bit instance, 1 = 24-bit instance
    longint unsigned mreg [2][8];
    longint unsigned mout [2];
    bit              mn [2], mv [2], mz [2];
    logic [15:0]     mir;
    int              wd [2] = '{16, 24};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] wrd);
        if (wrd[15:13] == 3'b110 && wrd[12:11] == 2'b10) return 2;
        if (wrd[15:13] == 3'b110 && wrd[12:11] == 2'b00) return 5;
        if (wrd[15:13] == 3'b101) return (wrd[12:11] == 2'b01) ? 4 : 5;
        return 1;
    endfunction

    function automatic longint signed to_signed(input longint unsigned x, input int wb);
        longint unsigned full = 64'd1 << wb;
        return (x >= (full >> 1)) ? longint'(x) - longint'(full) : longint'(x);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) mreg[k][r] = 0;
            mout[k] = 0; mn[k] = 0; mv[k] = 0; mz[k] = 0;
        end
        mir = 16'h0000;
    endtask

    task automatic model_exec(input logic [15:0] wrd);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        longint unsigned mask, a, b, r, imm;
        longint signed   sd;
        opc = wrd[15:13]; op = wrd[12:11]; rn = wrd[10:8];
        rd  = wrd[7:5];   sh = wrd[4:3];   rm = wrd[2:0];
        for (int k = 0; k < 2; k++) begin
            mask = (64'd1 << wd[k]) - 1;
            if (opc == 3'b110 && op == 2'b10) begin
                imm = longint'(wrd[7:0]);
                if (wrd[7]) imm = imm | (mask & ~64'hFF);
                mreg[k][rn] = imm;
            end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
                b = mreg[k][rm];
                case (sh)
                    2'b01:   b = (b * 2) & mask;
                    2'b10:   b = b / 2;
                    2'b11:   b = (b / 2) | (b & (64'd1 << (wd[k] - 1)));
                    default: b = b;
                endcase
                a = (opc == 3'b110) ? 0 : mreg[k][rn];
                if (opc == 3'b101 && op == 2'b01) begin
                    r  = (a - b) & mask;
                    sd = to_signed(a, wd[k]) - to_signed(b, wd[k]);
                    mn[k] = (r >> (wd[k] - 1)) != 0;
                    mz[k] = (r == 0);
                    mv[k] = (sd < -(longint'(1) << (wd[k] - 1))) ||
                            (sd > (longint'(1) << (wd[k] - 1)) - 1);
                end else begin
                    if (opc == 3'b110 || op == 2'b00) r = (a + b) & mask;
                    else if (op == 2'b10)             r = a & b;
                    else                              r = ~b & mask;
                    mout[k]     = r;
                    mreg[k][rd] = r;
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out16"}, 64'(out16), 64'(mout[0]));
        check({tag, "_flags16"}, 64'({n16, v16, z16}), 64'({mn[0], mv[0], mz[0]}));
        check({tag, "_out24"}, 64'(out24), 64'(mout[1]));
        check({tag, "_flags24"}, 64'({n24, v24, z24}), 64'({mn[1], mv[1], mz[1]}));
    endtask

    // Issue one instruction (optionally loading it) and wait for both CPUs to idle.
    // With glitch set, load is held high with a different word while busy.
    task automatic run(input logic [15:0] wrd, input bit with_load, input bit glitch);
        int n;
        bit done;
        @(negedge clk);
        in = wrd; load = with_load; s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0; load = 1'b0;
        if (with_load) mir = wrd;
        check("busy", 64'({w16, w24}), 64'(0));
        if (glitch) begin in = 16'hD1FF; load = 1'b1; end
        n = 0; done = 0;
        while (!done && n < 20) begin
            @(posedge clk); n++; #1;
            if (w16 && w24) done = 1;
        end
        load = 1'b0;
        check("latency", 64'(n), 64'(exp_lat(mir)));
        model_exec(mir);
        check_state("exec");
    endtask

    initial begin
        reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_w", 64'({w16, w24}), 64'(2'b11));
        check_state("rst");
        @(negedge clk); reset = 1'b1;

        // MOV imm, MOV-shift, ADD
        run(16'hD064, 1, 0);
        check("mov_imm_out", 64'(out16), 64'(0));
        run(16'hC030, 1, 0);
        check("lsr_r1", 64'(out16), 64'(50));
        run(16'hD09C, 1, 0);
        run(16'hC0D8, 1, 0);
        check("asr16", 64'(out16), 64'(16'hFFCE));
        run(16'hD064, 1, 0);
        run(16'hA041, 1, 0);
        check("add_r2", 64'(out16), 64'(150));

        // CMP overflow / zero cases
        run(16'hD3FF, 1, 0);
        run(16'hC073, 1, 0);
        run(16'hB883, 1, 0);
        check("mvn_r4", 64'(out16), 64'(16'h8000));
        run(16'hAB04, 1, 0);
        check("cmp_nvz", 64'({n16, v16, z16}), 64'(3'b110));
        run(16'hA800, 1, 0);
        check("cmp_zero", 64'({n16, v16, z16}), 64'(3'b001));

        // AND with load asserted while busy, then re-run held IR; MVN
        run(16'hB0A1, 1, 1);
        check("and_r5", 64'(out16), 64'(32));
        run(16'h0000, 0, 0);
        check("ir_held", 64'(out16), 64'(32));
        run(16'hB8C1, 1, 0);
        check("mvn_r6", 64'(out16), 64'(16'hFFCD));

        // Invalid opcodes
        run(16'h0000, 1, 0);
        run(16'hC800, 1, 0);
        run(16'hF8E7, 1, 0);

        // Sign-extended immediate 0x80
        run(16'hD580, 1, 0);
        run(16'hC0A5, 1, 0);
        check("sext24", 64'(out24), 64'(24'hFFFF80));

        // Reset during GET_B of ADD R2 aborts the write
        @(negedge clk);
        in = 16'hA041; load = 1'b1; s = 1'b1;
        @(posedge clk); #1; s = 1'b0; load = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; s = 1'b1; load = 1'b1; in = 16'hD2FF;
        @(posedge clk); #1;
        model_reset();
        check("abort_w", 64'({w16, w24}), 64'(2'b11));
        check_state("abort");
        s = 1'b0; load = 1'b0; reset = 1'b1;
        run(16'hC0E2, 1, 0);
        check("r2_cleared", 64'(out16), 64'(0));
        run(16'h0000, 0, 0);

        // Randomised instruction stream
        for (int t = 0; t < 150; t++) begin
            logic [15:0] wrd;
            int sel;
            bit wl, gl;
            wrd = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel <= 2)      wrd[15:11] = 5'b11010;
            else if (sel <= 4) wrd[15:11] = 5'b11000;
            else if (sel <= 8) wrd[15:13] = 3'b101;
            wl = ($urandom_range(0, 9) != 0);
            gl = ($urandom_range(0, 3) == 0);
            run(wrd, wl, gl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
